// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - EX-stage request/response bundle for the M-extension sequencer
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            reg_write;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  stall, busy, done, result, rd_out, reg_write
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output stall, busy, done, result, rd_out, reg_write
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer (shift-add / restoring divide)
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  state_t          state_nxt;

  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            neg_a_q;
  logic            neg_b_q;
  logic [XLEN-1:0] opnd_q;      // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q;        // product high half / partial remainder
  logic [XLEN-1:0] lo_q;        // multiplier bits / dividend bits, then quotient
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  // Operand decode at the decode/execute boundary
  logic            accept;
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   hi_step;
  logic [XLEN-1:0]   lo_step;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_res;
  logic              last;

  // Classify the incoming op and derive operand magnitudes and special cases
  always_comb begin
    accept      = (state == IDLE) && bus.start && !bus.flush;
    is_div      = bus.funct3[2];
    a_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                  (bus.funct3 == 3'b110);
    neg_a       = a_signed && bus.op_a[XLEN-1];
    neg_b       = b_signed && bus.op_b[XLEN-1];
    abs_a       = neg_a ? -bus.op_a : bus.op_a;
    abs_b       = neg_b ? -bus.op_b : bus.op_b;
    div_zero    = is_div && (bus.op_b == '0);
    // Only DIV/REM (funct3[0]==0) can overflow
    div_ovf     = is_div && !bus.funct3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    special     = div_zero || div_ovf;
    // funct3[1] separates remainder ops from quotient ops
    if (div_zero) begin
      special_res = bus.funct3[1] ? bus.op_a : '1;
    end else begin
      special_res = bus.funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One multiply or divide step, plus sign correction of the post-step values
  always_comb begin
    last    = (cnt_q == CW'(XLEN-1));
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    trial   = {hi_q, lo_q[XLEN-1]} - {1'b0, opnd_q};
    if (f3_q[2]) begin
      if (!trial[XLEN]) begin
        hi_step = trial[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_step = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_step = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      {hi_step, lo_step} = {mul_sum, lo_q[XLEN-1:1]};
    end
    prod     = {hi_step, lo_step};
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quot_fix = (neg_a_q ^ neg_b_q) ? -lo_step : lo_step;
    rem_fix  = neg_a_q ? -hi_step : hi_step;
    case (f3_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quot_fix;
      default:                final_res = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush wins over start and over finishing a calculation
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pipeline-facing outputs decoded from state
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.stall     = accept || (state == CALC);
    bus.reg_write = (state == DONE) && (rd_out_q != 5'd0);
    bus.result    = result_q;
    bus.rd_out    = rd_out_q;
  end

  // Operand capture, iteration registers and the held result/rd
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q     <= '0;
      rd_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (accept) begin
      f3_q    <= bus.funct3;
      rd_q    <= bus.rd_in;
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
      opnd_q  <= is_div ? abs_b : abs_a;
      lo_q    <= is_div ? abs_a : abs_b;
      hi_q    <= '0;
      cnt_q   <= '0;
      if (special) begin
        result_q <= special_res;
        rd_out_q <= bus.rd_in;
      end
    end else if ((state == CALC) && !bus.flush) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        result_q <= final_res;
        rd_out_q <= rd_q;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst;

  muldiv_seq_if #(.XLEN(32)) bus();

  muldiv_seq #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          cyc;
  bit          m_active;
  int          m_done_cyc;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  logic        exp_done;
  logic        exp_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) ||
                     (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  function automatic logic [31:0] model_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] up;
    longint      sp;
    int          sa;
    int          sb;
    bit          ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    up  = {32'd0, a} * {32'd0, b};
    case (f3)
      3'b000: return up[31:0];
      3'b001: begin
        sp = longint'(sa) * longint'(sb);
        return sp[63:32];
      end
      3'b010: begin
        sp = longint'(sa) * longint'({32'd0, b});
        return sp[63:32];
      end
      3'b011: return up[63:32];
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Timeline model: which cycle the op finishes in, and what it must produce
  initial begin
    cyc      = 0;
    m_active = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 1'b0;
      end else begin
        cyc++;
        if (m_active) begin
          if (bus.flush || (cyc > m_done_cyc)) m_active = 1'b0;
        end else if (bus.start && !bus.flush) begin
          m_active   = 1'b1;
          m_done_cyc = cyc + (is_special(bus.funct3, bus.op_a, bus.op_b) ? 0 : 32);
          m_res      = model_result(bus.funct3, bus.op_a, bus.op_b);
          m_rd       = bus.rd_in;
        end
      end
    end
  end

  // Every-cycle comparison of DUT control/result outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_done  = m_active && (cyc == m_done_cyc);
        exp_stall = (!m_active && bus.start && !bus.flush) || (m_active && (cyc != m_done_cyc));
        chk("ctl_stall_busy_done_wr",
            64'({bus.stall, bus.busy, bus.done, bus.reg_write}),
            64'({exp_stall, m_active, exp_done, exp_done && (m_rd != 5'd0)}));
        if (exp_done) begin
          chk("model_result", 64'(bus.result), 64'(m_res));
          chk("model_rd_out", 64'(bus.rd_out), 64'(m_rd));
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] lit);
    int stalls;
    int waitc;
    bit seen;
    int exp_lat;
    stalls  = 0;
    waitc   = 0;
    seen    = 1'b0;
    exp_lat = is_special(f3, a, b) ? 1 : 33;
    chk("pin_model", 64'(model_result(f3, a, b)), 64'(lit));
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    @(negedge clk);
    if (bus.stall) stalls++;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = ~a;
    bus.op_b  = ~b;
    bus.rd_in = ~rd;
    while (!seen && waitc < 40) begin
      @(negedge clk);
      waitc++;
      if (bus.done) begin
        seen = 1'b1;
        chk("lit_result", 64'(bus.result), 64'(lit));
        chk("lit_rd_out", 64'(bus.rd_out), 64'(rd));
        chk("lit_reg_write", 64'(bus.reg_write), 64'(rd != 5'd0));
      end else if (bus.stall) begin
        stalls++;
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    chk("latency", 64'(waitc), 64'(exp_lat));
    chk("stall_cycles", 64'(stalls), 64'(exp_lat));
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd0;
    bus.op_b   = 32'd0;
    bus.rd_in  = 5'd0;
    bus.flush  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_reg_write", 64'(bus.reg_write), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_rd_out", 64'(bus.rd_out), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE);
    run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF);
    run_op(3'b101, 32'd100,       32'd7,         5'd11, 32'd14);
    run_op(3'b111, 32'd100,       32'd7,         5'd0,  32'd2);
    run_op(3'b101, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF);
    run_op(3'b110, 32'd5,         32'd0,         5'd13, 32'd5);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000);

    // Flush at CALC iteration 10
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'h0000_1234;
    bus.op_b   = 32'h0000_0010;
    bus.rd_in  = 5'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1;
    chk("flush_no_done", 64'(bus.done), 64'd0);
    run_op(3'b000, 32'd3, 32'd4, 5'd20, 32'd12);

    // Asynchronous reset in the middle of a calculation
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd5;
    bus.op_b   = 32'd6;
    bus.rd_in  = 5'd21;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_done", 64'(bus.done), 64'd0);
    chk("async_rst_result", 64'(bus.result), 64'd0);
    chk("async_rst_rd_out", 64'(bus.rd_out), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(3'b101, 32'd9, 32'd3, 5'd22, 32'd3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
